cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 10, meaning word address width.
REQ-002 Parameter: DATA_W, default 32, meaning word width.
REQ-003 Parameter: INDEX_W, default 5, meaning line index width (32 lines; 4 words/line; tag width = ADDR_W-INDEX_W-2 = 3).
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: cpu_read  input  1  CPU load request; held stable while stall=1.
REQ-007 Port: cpu_write  input  1  CPU store request.
REQ-008 Port: cpu_addr  input  ADDR_W  word address; [9:7] tag, [6:2] index, [1:0] offset.
REQ-009 Port: cpu_wdata  input  DATA_W  store data.
REQ-010 Port: cpu_rdata  output  DATA_W  load data; valid when cpu_read=1 and stall=0.
REQ-011 Port: stall  output  1  CPU must hold its request and wait.
REQ-012 Port: mem_read  output  1  block-fill request to data memory.
REQ-013 Port: mem_write  output  1  write-through strobe to data memory (memory captures on falling clk edge).
REQ-014 Port: mem_addr  output  ADDR_W  memory word address.
REQ-015 Port: mem_wdata  output  DATA_W  write-through data.
REQ-016 Port: mem_counter  output  2  word-within-block selector during fill.
REQ-017 Port: mem_rdata  input  DATA_W  fill word selected by mem_counter (combinational from memory).
REQ-018 Port: mem_ready  input  1  high while mem_counter=3 during fill (last word).

Function
REQ-019 Direct-mapped, 32 lines x 4 words; per line one valid bit and one 3-bit tag.
REQ-020 Hit = line[index].valid and line[index].tag = cpu_addr tag.
REQ-021 FSM states: IDLE, FILL; no other states.
REQ-022 IDLE, cpu_read hit: cpu_rdata = line word[offset] combinationally, stall=0, zero-cycle latency.
REQ-023 IDLE, cpu_read miss: stall=1 that cycle; latch block address cpu_addr[9:2]; counter<=0; next state FILL.
REQ-024 FILL: mem_read=1, stall=1, mem_addr={latched block,2'b00}, mem_counter=counter; each rising edge writes mem_rdata into line word[counter] and counter<=counter+1.
REQ-025 FILL exit: on the rising edge where mem_ready=1 (counter=3), set valid, write tag, next state IDLE; counter wraps to 0.
REQ-026 Read-miss timing: miss cycle + 4 FILL cycles stalled; the held request hits in the 6th cycle.
REQ-027 Write policy write-through, no-write-allocate: IDLE with cpu_write drives mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata in the same cycle; stall=0.
REQ-028 Write hit: additionally updates line word[offset] at the rising edge; valid/tag unchanged.
REQ-029 Write miss: cache contents unchanged.
REQ-030 cpu_read and cpu_write both high: treated as write only; cpu_rdata = 0.
REQ-031 Requests arriving while in FILL are ignored (CPU stalled); mem_write=0 in FILL.
REQ-032 Outputs when idle with no request: mem_read=0, mem_write=0, mem_counter=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, stall=0.

Reset
REQ-033 rst=1 asynchronously forces state IDLE, counter=0, latched block=0, all valid bits=0; data/tag arrays not cleared.
REQ-034 rst asserted mid-FILL aborts the fill: mem_read drops immediately, partial line stays invalid.
REQ-035 All outputs take REQ-032 values while rst=1.

Structure
REQ-036 Package cache_pkg holds ADDR_W, DATA_W, INDEX_W, TAG_W, OFFSET_W=2, and the state enum {IDLE, FILL}.
REQ-037 One sub-module cache_array: valid/tag/data storage, combinational read, synchronous word write, async valid clear.

Verification
REQ-038 Reset then read 0x014 (mem[0x014..0x017]=A0..A3) -> stall 5 cycles, mem_counter 0,1,2,3, cpu_rdata=A0 in 6th cycle.
REQ-039 After REQ-038, read 0x016 -> stall=0, cpu_rdata=A2 same cycle, mem_read=0.
REQ-040 Write 0x015 data 0xDEADBEEF (hit) -> mem_write=1 one cycle, mem[0x015]=0xDEADBEEF; next read 0x015 hits, returns 0xDEADBEEF.
REQ-041 Write 0x3F0 (miss) -> mem updated, no fill; subsequent read 0x3F0 misses and fills with new value.
REQ-042 Read 0x094 (same index as 0x014, tag 1) -> miss, line replaced; then read 0x014 -> miss again.
REQ-043 rst pulse during FILL counter=2 -> mem_read=0 immediately; re-read same address misses and fills fully.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared sizing and state encoding for the direct-mapped write-through cache controller.
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: combinational read port, one synchronous word write port,
// tag+valid update on line fill completion, and an asynchronously cleared valid vector.
module cache_array #(
    parameter int DATA_W   = cache_pkg::DATA_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int TAG_W    = cache_pkg::TAG_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                tag_wr_en,
    input  logic [TAG_W-1:0]    tag_wdata
);
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = LINES << OFFSET_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage are deliberately left out of reset; valid alone gates hits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_wr_en) begin
            tags[wr_index] <= tag_wdata;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_offset}];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a 4-word block fill.
// state | meaning
// IDLE  | serve read hits and write-throughs; a read miss latches the block and starts a fill
// FILL  | stream 4 words from memory into the line, CPU stalled; set valid/tag on the last word
module cache_ctrl #(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int DATA_W  = cache_pkg::DATA_W,
    parameter int INDEX_W = cache_pkg::INDEX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_counter,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import cache_pkg::*;

    localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLK_W    = ADDR_W - OFFSET_W;

    state_t              state;
    logic [1:0]          counter;
    logic [BLK_W-1:0]    blk;

    logic [INDEX_W-1:0]  cpu_index;
    logic [OFFSET_W-1:0] cpu_offset;
    logic [TAG_BITS-1:0] cpu_tag;
    logic                hit;

    logic                arr_valid;
    logic [TAG_BITS-1:0] arr_tag;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_wr_en;
    logic [INDEX_W-1:0]  arr_wr_index;
    logic [OFFSET_W-1:0] arr_wr_offset;
    logic [DATA_W-1:0]   arr_wr_data;
    logic                arr_tag_wr_en;

    assign cpu_index  = cpu_addr[OFFSET_W +: INDEX_W];
    assign cpu_offset = cpu_addr[OFFSET_W-1:0];
    assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_BITS];
    assign hit        = arr_valid && (arr_tag == cpu_tag);

    cache_array #(
        .DATA_W   (DATA_W),
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_BITS),
        .OFFSET_W (OFFSET_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (cpu_index),
        .rd_offset (cpu_offset),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_rdata),
        .wr_en     (arr_wr_en),
        .wr_index  (arr_wr_index),
        .wr_offset (arr_wr_offset),
        .wr_data   (arr_wr_data),
        .tag_wr_en (arr_tag_wr_en),
        .tag_wdata (blk[BLK_W-1 -: TAG_BITS])
    );

    // Outputs are decoded from the registered state so the fill request drops the
    // instant reset clears the state, and hits/write-throughs need no extra cycle.
    always_comb begin
        cpu_rdata     = '0;
        stall         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_counter   = 2'd0;
        arr_wr_en     = 1'b0;
        arr_wr_index  = cpu_index;
        arr_wr_offset = cpu_offset;
        arr_wr_data   = cpu_wdata;
        arr_tag_wr_en = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                if (cpu_write) begin
                    mem_write = 1'b1;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    arr_wr_en = hit;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = arr_rdata;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end else begin
                stall         = 1'b1;
                mem_read      = 1'b1;
                mem_addr      = {blk, {OFFSET_W{1'b0}}};
                mem_counter   = counter;
                arr_wr_en     = 1'b1;
                arr_wr_index  = blk[INDEX_W-1:0];
                arr_wr_offset = counter;
                arr_wr_data   = mem_rdata;
                arr_tag_wr_en = mem_ready;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= 2'd0;
            blk     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_read && !cpu_write && !hit) begin
                        blk     <= cpu_addr[ADDR_W-1:OFFSET_W];
                        counter <= 2'd0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    counter <= counter + 2'd1;
                    if (mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
